// File: rtl/input_debouncer_if.sv
// Board-input bundle between the raw switch/button pins and the input buffer.
// The debouncer sits on the slave side; the stimulus/consumer side uses master.
interface input_debouncer_if;
  logic [31:0] i_io_sw;
  logic [3:0]  i_io_btn;
  logic [3:0]  i_clr_sticky;
  logic [31:0] o_io_sw;
  logic [3:0]  o_io_btn;
  logic [3:0]  o_btn_press;
  logic [3:0]  o_btn_sticky;

  modport slave (
    input  i_io_sw, i_io_btn, i_clr_sticky,
    output o_io_sw, o_io_btn, o_btn_press, o_btn_sticky
  );

  modport master (
    output i_io_sw, i_io_btn, i_clr_sticky,
    input  o_io_sw, o_io_btn, o_btn_press, o_btn_sticky
  );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchronizers for the 32 board switches and 4 buttons. Each button
// also gets a saturating mismatch counter, a press pulse and a sticky press flag.
module input_debouncer #(
  parameter int DB_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input_debouncer_if.slave   io
);
  localparam int NUM_BTN = 4;
  localparam int CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [31:0] r_sw_meta, r_sw_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= io.i_io_sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign io.o_io_sw = r_sw_sync;

  logic [NUM_BTN-1:0] w_deb, w_press, w_sticky;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    logic             r_meta, r_sync, r_deb, r_press, r_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mis, w_accept;

    assign w_mis    = (r_sync != r_deb);
    // The DB_CYCLES-th consecutive mismatch is accepted instead of counted,
    // so the counter saturates at DB_CYCLES-1 and never wraps.
    assign w_accept = w_mis && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_meta   <= 1'b0;
        r_sync   <= 1'b0;
        r_cnt    <= '0;
        r_deb    <= 1'b0;
        r_press  <= 1'b0;
        r_sticky <= 1'b0;
      end else begin
        r_meta <= io.i_io_btn[g];
        r_sync <= r_meta;
        if (!w_mis || w_accept) r_cnt <= '0;
        else                    r_cnt <= r_cnt + 1'b1;
        if (w_accept) r_deb <= r_sync;
        r_press  <= w_accept & r_sync;
        // A press landing with a clear request keeps the flag set.
        r_sticky <= r_press | (r_sticky & ~io.i_clr_sticky[g]);
      end
    end

    assign w_deb[g]    = r_deb;
    assign w_press[g]  = r_press;
    assign w_sticky[g] = r_sticky;
  end

  assign io.o_io_btn     = w_deb;
  assign io.o_btn_press  = w_press;
  assign io.o_btn_sticky = w_sticky;
endmodule

// File: tb/tb_input_debouncer.sv
// Randomized bench for input_debouncer; a sample-history reference model
// predicts every output each cycle alongside directed scenario checks.
module tb_input_debouncer;
  localparam int DB = 4;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  input_debouncer_if bus();

  input_debouncer #(.DB_CYCLES(DB)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .io      (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: raw-sample histories; a button level flips once the
  // last DB synchronized samples all disagree with the current level.
  logic [31:0] m_swq[$];
  logic [3:0]  m_bq[$];
  logic [3:0]  m_sv[$];
  logic [31:0] m_sw;
  logic [3:0]  m_deb, m_press, m_sticky;

  task automatic model_reset();
    m_swq = {32'h0, 32'h0};
    m_bq  = {4'h0, 4'h0};
    m_sv  = {};
    m_sw = '0; m_deb = '0; m_press = '0; m_sticky = '0;
  endtask

  task automatic model_edge(input logic [31:0] sw, input logic [3:0] btn, input logic [3:0] clr);
    logic [3:0] s, nd;
    bit all;
    s = m_bq[m_bq.size()-2];
    m_sv.push_back(s);
    while (m_sv.size() > DB) void'(m_sv.pop_front());
    nd = m_deb;
    for (int i = 0; i < 4; i++) begin
      all = (m_sv.size() >= DB);
      for (int j = 0; j < m_sv.size(); j++)
        if (m_sv[j][i] == m_deb[i]) all = 0;
      if (all) nd[i] = ~m_deb[i];
    end
    m_sticky = m_press | (m_sticky & ~clr);
    m_press  = nd & ~m_deb;
    m_deb    = nd;
    m_sw     = m_swq[m_swq.size()-1];
    m_swq.push_back(sw);
    m_bq.push_back(btn);
    while (m_swq.size() > 2) void'(m_swq.pop_front());
    while (m_bq.size() > 2) void'(m_bq.pop_front());
  endtask

  // Drive at the falling edge, clock once, land on the next falling edge.
  task automatic step(input logic [31:0] sw, input logic [3:0] btn, input logic [3:0] clr);
    bus.i_io_sw = sw; bus.i_io_btn = btn; bus.i_clr_sticky = clr;
    @(posedge i_clk);
    if (i_rst_n) model_edge(sw, btn, clr);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step($urandom, 4'($urandom), 4'($urandom));
      n_checks++;
      if ({bus.o_io_sw, bus.o_io_btn, bus.o_btn_press, bus.o_btn_sticky} !== 44'h0) begin
        n_errors++;
        $display("FAIL reset_hold: got sw=%h btn=%h press=%h sticky=%h want all 0",
                 bus.o_io_sw, bus.o_io_btn, bus.o_btn_press, bus.o_btn_sticky);
      end
    end
    #2 i_rst_n = 1'b1;
    step($urandom, 4'($urandom), 4'($urandom));
    n_checks++;
    if ({bus.o_io_sw, bus.o_io_btn, bus.o_btn_press, bus.o_btn_sticky} !== 44'h0) begin
      n_errors++;
      $display("FAIL reset_first_edge: got sw=%h btn=%h press=%h sticky=%h want all 0",
               bus.o_io_sw, bus.o_io_btn, bus.o_btn_press, bus.o_btn_sticky);
    end
  endtask

  task automatic test_switch();
    for (int c = 0; c < 14; c++) step(32'h0, 4'h0, 4'hF);
    n_checks++;
    if (bus.o_io_sw !== 32'h0 || bus.o_btn_sticky !== 4'h0 || bus.o_io_btn !== 4'h0) begin
      n_errors++;
      $display("FAIL settle: got sw=%h btn=%h sticky=%h want 0", bus.o_io_sw, bus.o_io_btn, bus.o_btn_sticky);
    end
    step(32'h3, 4'h0, 4'h0);
    n_checks++;
    if (bus.o_io_sw !== 32'h0) begin
      n_errors++;
      $display("FAIL sw_edge_k: got %h want 00000000", bus.o_io_sw);
    end
    step(32'h3, 4'h0, 4'h0);
    n_checks++;
    if (bus.o_io_sw !== 32'h3) begin
      n_errors++;
      $display("FAIL sw_edge_k1: got %h want 00000003", bus.o_io_sw);
    end
    step(32'h0, 4'h0, 4'h0);
    step(32'h0, 4'h0, 4'h0);
    n_checks++;
    if (bus.o_io_sw !== m_sw) begin
      n_errors++;
      $display("FAIL sw_model: got %h want %h", bus.o_io_sw, m_sw);
    end
  endtask

  task automatic test_press();
    int first = 0, pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      step(32'h0, 4'b0010, 4'h0);
      if (first == 0 && bus.o_io_btn == 4'b0010) first = c;
      if (bus.o_btn_press != 4'h0) begin
        pulses++;
        n_checks++;
        if (bus.o_btn_press !== 4'b0010 || c != first) begin
          n_errors++;
          $display("FAIL press_value: got %b at step %0d want 0010 at step %0d", bus.o_btn_press, c, first);
        end
      end
      n_checks++;
      if (bus.o_io_btn !== m_deb || bus.o_btn_press !== m_press) begin
        n_errors++;
        $display("FAIL press_model: got btn=%b press=%b want btn=%b press=%b",
                 bus.o_io_btn, bus.o_btn_press, m_deb, m_press);
      end
    end
    n_checks++;
    if (first != DB + 2) begin
      n_errors++;
      $display("FAIL press_latency: got step %0d want %0d", first, DB + 2);
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL press_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if (bus.o_btn_sticky !== 4'b0010) begin
      n_errors++;
      $display("FAIL press_sticky: got %b want 0010", bus.o_btn_sticky);
    end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step(32'h0, 4'b0000, 4'h0);
      if (bus.o_btn_press != 4'h0) pulses++;
    end
    n_checks++;
    if (pulses != 0 || bus.o_io_btn !== 4'h0 || bus.o_btn_sticky !== 4'b0010) begin
      n_errors++;
      $display("FAIL release: got pulses=%0d btn=%b sticky=%b want 0 0000 0010",
               pulses, bus.o_io_btn, bus.o_btn_sticky);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat [12] = '{1,1,1,0,0,0,1,1,1,0,0,0};
    for (int c = 0; c < 22; c++) begin
      step(32'h0, (c < 12) ? pat[c] : 4'h0, 4'h0);
      n_checks++;
      if (bus.o_io_btn[0] !== 1'b0 || bus.o_btn_press[0] !== 1'b0) begin
        n_errors++;
        $display("FAIL bounce: step %0d got btn0=%b press0=%b want 0 0", c, bus.o_io_btn[0], bus.o_btn_press[0]);
      end
    end
  endtask

  task automatic test_sticky_collision();
    bit found = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      step(32'h0, 4'b0100, 4'h0);
      if (bus.o_btn_press[2]) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL collide_timeout: got no press on btn2 want one within 12 edges");
    end
    step(32'h0, 4'b0100, 4'b0100);
    n_checks++;
    if (bus.o_btn_sticky !== 4'b0110 || bus.o_btn_press !== 4'h0) begin
      n_errors++;
      $display("FAIL collide_set_wins: got sticky=%b press=%b want 0110 0000", bus.o_btn_sticky, bus.o_btn_press);
    end
  endtask

  task automatic test_sticky_clear();
    step(32'h0, 4'b0100, 4'b0100);
    n_checks++;
    if (bus.o_btn_sticky !== 4'b0010) begin
      n_errors++;
      $display("FAIL clear_bit2: got %b want 0010", bus.o_btn_sticky);
    end
    step(32'h0, 4'b0100, 4'b1000);
    n_checks++;
    if (bus.o_btn_sticky !== 4'b0010) begin
      n_errors++;
      $display("FAIL clear_zero_flag: got %b want 0010", bus.o_btn_sticky);
    end
  endtask

  task automatic test_reset_mid();
    int first = 0, pulses = 0;
    for (int c = 0; c < 4; c++) step(32'h0, 4'b1000, 4'h0);
    n_checks++;
    if (bus.o_io_btn[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_pre: got btn3=%b want 0", bus.o_io_btn[3]);
    end
    i_rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({bus.o_io_sw, bus.o_io_btn, bus.o_btn_press, bus.o_btn_sticky} !== 44'h0) begin
      n_errors++;
      $display("FAIL async_reset: got sw=%h btn=%h press=%h sticky=%h want all 0",
               bus.o_io_sw, bus.o_io_btn, bus.o_btn_press, bus.o_btn_sticky);
    end
    @(negedge i_clk);
    step(32'h0, 4'b1000, 4'h0);
    step(32'h0, 4'b1000, 4'h0);
    i_rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step(32'h0, 4'b1000, 4'h0);
      if (first == 0 && bus.o_io_btn[3]) first = c;
      if (bus.o_btn_press[3]) pulses++;
      n_checks++;
      if (bus.o_io_btn !== m_deb || bus.o_btn_press !== m_press || bus.o_btn_sticky !== m_sticky) begin
        n_errors++;
        $display("FAIL midreset_model: got btn=%b press=%b sticky=%b want %b %b %b",
                 bus.o_io_btn, bus.o_btn_press, bus.o_btn_sticky, m_deb, m_press, m_sticky);
      end
    end
    n_checks++;
    if (first != DB + 2 || pulses != 1) begin
      n_errors++;
      $display("FAIL midreset_latency: got step %0d pulses %0d want step %0d pulses 1", first, pulses, DB + 2);
    end
  endtask

  task automatic test_random();
    logic [3:0] btn = 4'h0;
    logic [3:0] clr;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(5) == 0) btn[i] = ~btn[i];
      clr = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      step($urandom, btn, clr);
      n_checks++;
      if (bus.o_io_sw !== m_sw || bus.o_io_btn !== m_deb ||
          bus.o_btn_press !== m_press || bus.o_btn_sticky !== m_sticky) begin
        n_errors++;
        $display("FAIL random_%0d: got sw=%h btn=%b press=%b sticky=%b want sw=%h btn=%b press=%b sticky=%b",
                 c, bus.o_io_sw, bus.o_io_btn, bus.o_btn_press, bus.o_btn_sticky,
                 m_sw, m_deb, m_press, m_sticky);
      end
    end
  endtask

  initial begin
    bus.i_io_sw = '0; bus.i_io_btn = '0; bus.i_clr_sticky = '0;
    @(negedge i_clk);
    test_reset();
    test_switch();
    test_press();
    test_bounce();
    test_sticky_collision();
    test_sticky_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end
endmodule
